// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the imem boot loader.
// Revision    : 1.0 - initial release
// ============================================================================

package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    localparam logic [7:0] c_MAGIC_DEFAULT  = 8'hA5;
    localparam int         c_LEN_W          = 16;
    localparam int         c_BYTES_PER_WORD = 4;
    localparam logic [3:0] c_WEA_ALL        = 4'hF;
    localparam logic [7:0] c_CSUM_INIT      = 8'h00;

    // Frame bytes are only accepted while a frame can still be in progress.
    function automatic logic state_accepts(input state_t s);
        return !((s == ST_DONE) || (s == ST_ERR));
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_byte_packer
// Description : Packs a little-endian byte stream into 32-bit words.
// Revision    : 1.0 - initial release
// ============================================================================

module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_last_lane,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    localparam logic [1:0] c_LAST_LANE = 2'(c_BYTES_PER_WORD - 1);

    logic [1:0]  r_lane;
    logic [23:0] r_shift;
    logic        r_word_valid;
    logic [31:0] r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane       <= 2'd0;
            r_shift      <= 24'd0;
            r_word_valid <= 1'b0;
            r_word       <= 32'd0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_lane <= 2'd0;
            end else if (i_byte_valid) begin
                r_lane  <= r_lane + 2'd1;
                r_shift <= {i_byte, r_shift[23:8]};
                // Earliest byte has shifted down to [7:0] by the fourth lane.
                if (r_lane == c_LAST_LANE) begin
                    r_word_valid <= 1'b1;
                    r_word       <= {i_byte, r_shift};
                end
            end
        end
    end

    assign o_last_lane  = (r_lane == c_LAST_LANE);
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Frames a boot byte stream, writes it into imem, releases core.
// Revision    : 1.0 - initial release
// ============================================================================

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W      = 14,
    parameter logic [7:0] MAGIC       = c_MAGIC_DEFAULT,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              restart,
    output logic              imem_ena,
    output logic [3:0]        imem_wea,
    output logic [ADDR_W-1:0] imem_addra,
    output logic [31:0]       imem_dina,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [31:0] c_MAX_WORDS    = 32'd1 << ADDR_W;
    localparam bit          c_TIMEOUT_EN   = (TIMEOUT_CYC > 0);
    localparam logic [31:0] c_TIMEOUT_LAST = c_TIMEOUT_EN ? 32'(TIMEOUT_CYC - 1) : 32'd0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rx_ready;
    logic                r_core_rst;
    logic                r_load_done;
    logic                r_load_err;
    logic [ADDR_W-1:0]   r_addra;
    logic [c_LEN_W-1:0]  r_len;
    logic [ADDR_W:0]     r_word_idx;
    logic [7:0]          r_csum;
    logic [31:0]         r_timer;

    logic                w_xfer;
    logic                w_active;
    logic                w_enter_len0;
    logic                w_timeout;
    logic                w_data_byte;
    logic                w_word_done;
    logic                w_last_lane;
    logic                w_last_word;
    logic                w_word_valid;
    logic [31:0]         w_word;
    logic [c_LEN_W-1:0]  w_len_hdr;
    logic                w_len_too_big;

    assign w_xfer       = rx_valid & r_rx_ready;
    assign w_active     = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                          (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_enter_len0 = (r_state == ST_IDLE) && w_xfer && (rx_data == MAGIC);
    assign w_timeout    = c_TIMEOUT_EN && w_active && !w_xfer &&
                          (r_timer == c_TIMEOUT_LAST);
    assign w_data_byte  = (r_state == ST_DATA) && w_xfer;
    assign w_word_done  = w_data_byte && w_last_lane;
    assign w_last_word  = ((32'(r_word_idx) + 32'd1) == 32'(r_len));
    assign w_len_hdr    = {rx_data, r_len[7:0]};
    // A full-size image (exactly 2**ADDR_W words) is legal; only larger is rejected.
    assign w_len_too_big = (32'(w_len_hdr) > c_MAX_WORDS);

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_enter_len0),
        .i_byte_valid (w_data_byte),
        .i_byte       (rx_data),
        .o_last_lane  (w_last_lane),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_enter_len0) w_state_nxt = ST_LEN0;
            end
            ST_LEN0: begin
                if (w_xfer)         w_state_nxt = ST_LEN1;
                else if (w_timeout) w_state_nxt = ST_ERR;
            end
            ST_LEN1: begin
                if (w_xfer) begin
                    if (w_len_too_big)          w_state_nxt = ST_ERR;
                    else if (w_len_hdr == '0)   w_state_nxt = ST_CSUM;
                    else                        w_state_nxt = ST_DATA;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_DATA: begin
                if (w_word_done && w_last_word) w_state_nxt = ST_CSUM;
                else if (w_timeout)             w_state_nxt = ST_ERR;
            end
            ST_CSUM: begin
                if (w_xfer)         w_state_nxt = (rx_data == r_csum) ? ST_DONE : ST_ERR;
                else if (w_timeout) w_state_nxt = ST_ERR;
            end
            ST_DONE, ST_ERR: begin
                if (restart) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rx_ready  <= 1'b1;
            r_core_rst  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_addra     <= '0;
            r_len       <= '0;
            r_word_idx  <= '0;
            r_csum      <= c_CSUM_INIT;
            r_timer     <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_rx_ready  <= state_accepts(w_state_nxt);
            r_core_rst  <= (w_state_nxt != ST_DONE);
            r_load_done <= (w_state_nxt == ST_DONE);
            r_load_err  <= (w_state_nxt == ST_ERR);

            if (w_enter_len0) begin
                r_csum     <= c_CSUM_INIT;
                r_word_idx <= '0;
                r_timer    <= 32'd0;
            end else begin
                if (w_active) begin
                    if (w_xfer)            r_timer <= 32'd0;
                    else if (c_TIMEOUT_EN) r_timer <= r_timer + 32'd1;
                end
                if ((r_state == ST_LEN0) && w_xfer) r_len <= {8'h00, rx_data};
                if ((r_state == ST_LEN1) && w_xfer) r_len <= w_len_hdr;
                if (w_data_byte) r_csum <= r_csum ^ rx_data;
                // Address is latched alongside the packer's word so both land in the same cycle.
                if (w_word_done) begin
                    r_addra    <= r_word_idx[ADDR_W-1:0];
                    r_word_idx <= r_word_idx + (ADDR_W+1)'(1);
                end
            end
        end
    end

    assign rx_ready   = r_rx_ready;
    assign imem_ena   = w_word_valid;
    assign imem_wea   = w_word_valid ? c_WEA_ALL : 4'h0;
    assign imem_addra = r_addra;
    assign imem_dina  = w_word;
    assign core_rst   = r_core_rst;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_imem_loader;

    localparam int ADDR_W = 14;
    localparam int TO_CYC = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              restart;
    logic              imem_ena;
    logic [3:0]        imem_wea;
    logic [ADDR_W-1:0] imem_addra;
    logic [31:0]       imem_dina;
    logic              core_rst;
    logic              load_done;
    logic              load_err;

    imem_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .restart    (restart),
        .imem_ena   (imem_ena),
        .imem_wea   (imem_wea),
        .imem_addra (imem_addra),
        .imem_dina  (imem_dina),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    int          bad_pulse = 0;
    logic        prev_ena = 1'b0;
    logic        mon_clr = 1'b0;
    logic [31:0] mem [int];

    // Payload XOR: 13^93^10 = 0x90.
    logic [7:0] frame_a [11] = '{8'hA5, 8'h02, 8'h00,
                                 8'h13, 8'h00, 8'h00, 8'h00,
                                 8'h93, 8'h00, 8'h10, 8'h00};

    // Write monitor: records imem contents and flags malformed write pulses.
    always @(negedge clk) begin
        if (mon_clr) begin
            mem.delete();
            wr_cnt    = 0;
            bad_pulse = 0;
            prev_ena  = 1'b0;
        end else begin
            if (imem_ena) begin
                mem[int'(imem_addra)] = imem_dina;
                wr_cnt++;
                if (imem_wea !== 4'hF || prev_ena) bad_pulse++;
            end else if (imem_wea !== 4'h0) begin
                bad_pulse++;
            end
            prev_ena = imem_ena;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input int a);
        return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] csum, input int gap);
        for (int i = 0; i < 11; i++) send_byte(frame_a[i], gap);
        send_byte(csum, gap);
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        tick();
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    // Packs {rx_ready, core_rst, load_done, load_err} for compact status checks.
    function automatic logic [63:0] status();
        return {60'd0, rx_ready, core_rst, load_done, load_err};
    endfunction

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; restart = 1'b0;
        tick();
        chk("reset_status", status(), 64'b1100);
        chk("reset_imem", {imem_ena, imem_wea, imem_addra, imem_dina}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Case 1: two-word image at full rate.
        clear_mon();
        for (int i = 0; i < 11; i++) send_byte(frame_a[i], 0);
        chk("c1_pre_csum_status", status(), 64'b1100);
        send_byte(8'h90, 0);
        chk("c1_done_status", status(), 64'b0010);
        chk("c1_wr_cnt", 64'(wr_cnt), 64'd2);
        chk("c1_mem0", 64'(mem_word(0)), 64'h0000_0013);
        chk("c1_mem1", 64'(mem_word(1)), 64'h0010_0093);
        chk("c1_bad_pulse", 64'(bad_pulse), 64'd0);
        send_byte(8'hA5, 0);
        chk("c1_done_sticky", status(), 64'b0010);
        pulse_restart();
        chk("c1_restart_status", status(), 64'b1100);

        // Case 2: checksum mismatch.
        clear_mon();
        send_frame(8'h81, 0);
        chk("c2_err_status", status(), 64'b0101);
        chk("c2_wr_cnt", 64'(wr_cnt), 64'd2);
        pulse_restart();
        chk("c2_restart_status", status(), 64'b1100);

        // Case 3: leading junk, plus a restart pulse mid-frame that must be ignored.
        clear_mon();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        chk("c3_junk_status", status(), 64'b1100);
        chk("c3_junk_wr_cnt", 64'(wr_cnt), 64'd0);
        for (int i = 0; i < 4; i++) send_byte(frame_a[i], 0);
        restart = 1'b1;
        send_byte(frame_a[4], 0);
        restart = 1'b0;
        for (int i = 5; i < 11; i++) send_byte(frame_a[i], 0);
        send_byte(8'h90, 0);
        chk("c3_done_status", status(), 64'b0010);
        chk("c3_mem", {mem_word(1), mem_word(0)}, 64'h0010_0093_0000_0013);
        chk("c3_wr_cnt", 64'(wr_cnt), 64'd2);
        pulse_restart();

        // Case 4: oversize length, then the largest legal length.
        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h40, 0);
        chk("c4_too_big_status", status(), 64'b0101);
        chk("c4_wr_cnt", 64'(wr_cnt), 64'd0);
        pulse_restart();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        chk("c4_max_len_status", status(), 64'b1100);
        repeat (TO_CYC) tick();
        chk("c4_max_len_timeout", status(), 64'b0101);
        pulse_restart();

        // Case 5: timeout inside DATA, then reset during a write pulse.
        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (TO_CYC - 1) tick();
        chk("c5_before_timeout", status(), 64'b1100);
        tick();
        chk("c5_timeout", status(), 64'b0101);
        pulse_restart();
        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        chk("c5_pulse_before_rst", {imem_ena, imem_wea, imem_dina}, {27'd0, 1'b1, 4'hF, 32'h4433_2211});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("c5_rst_imem", {imem_ena, imem_wea, imem_addra, imem_dina}, 64'd0);
        chk("c5_rst_status", status(), 64'b1100);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        tick();
        chk("c5_no_writes_after_rst", 64'(wr_cnt), 64'd1);
        chk("c5_partial_word", 64'(mem_word(0)), 64'h4433_2211);

        // Case 6: empty image, then the two-word image with rx gaps.
        clear_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("c6_empty_pre_csum", status(), 64'b1100);
        send_byte(8'h00, 0);
        chk("c6_empty_done", status(), 64'b0010);
        chk("c6_empty_wr_cnt", 64'(wr_cnt), 64'd0);
        pulse_restart();
        clear_mon();
        send_frame(8'h90, 2);
        chk("c6_gap_done", status(), 64'b0010);
        chk("c6_gap_mem", {mem_word(1), mem_word(0)}, 64'h0010_0093_0000_0013);
        chk("c6_gap_wr_cnt", 64'(wr_cnt), 64'd2);
        chk("c6_gap_bad_pulse", 64'(bad_pulse), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
